// File: rtl/exhaustive_stim_gen.sv
// ============================================================================
// Module   : exhaustive_stim_gen
// Purpose  : Sweeps every N-bit input code, holding each for DWELL cycles. At
//            the end of each hold it checks f_in against EXP_TABLE[vec] and
//            counts the mismatches.
//            Build macro STIM_GRAY_EN selects reflected Gray ordering.
//            Without it the codes are applied in binary ascending order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exhaustive_stim_gen #(
    parameter int                N         = 4,
    parameter int                DWELL     = 20,
    parameter logic [(1<<N)-1:0] EXP_TABLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         f_in,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec,
    output logic         first_err_vld
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] C_IDX_ZERO   = '0;
    localparam logic [N-1:0] C_IDX_ONE    = N'(1);
    localparam logic [N-1:0] C_IDX_LAST   = {N{1'b1}};
    localparam logic [15:0]  C_DWELL_LAST = 16'(DWELL - 1);
    localparam logic [N:0]   C_ERR_ONE    = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   C_ERR_MAX    = {1'b1, {N{1'b0}}};

    state_t       r_state;
    logic [N-1:0] r_index;
    logic [15:0]  r_dwell;

    logic         w_compare;
    logic         w_mismatch;
    logic [N-1:0] w_next_index;

    // Maps the sweep index to the code driven on vec.
    function automatic logic [N-1:0] code_of(input logic [N-1:0] idx);
`ifdef STIM_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    assign w_compare    = (r_dwell == C_DWELL_LAST);
    assign w_mismatch   = (f_in != EXP_TABLE[vec]);
    assign w_next_index = r_index + C_IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_dwell       <= '0;
            vec           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        r_state       <= ST_RUN;
                        r_index       <= '0;
                        r_dwell       <= '0;
                        vec           <= code_of(C_IDX_ZERO);
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_vec <= '0;
                        first_err_vld <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        // Cancel keeps the error results seen so far.
                        r_state <= ST_IDLE;
                        r_index <= '0;
                        r_dwell <= '0;
                        vec     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (w_compare) begin
                        if (w_mismatch) begin
                            if (err_cnt != C_ERR_MAX) begin
                                err_cnt <= err_cnt + C_ERR_ONE;
                            end
                            if (!first_err_vld) begin
                                first_err_vec <= vec;
                                first_err_vld <= 1'b1;
                            end
                        end
                        r_dwell <= '0;
                        if (r_index == C_IDX_LAST) begin
                            r_state <= ST_DONE;
                            r_index <= '0;
                            vec     <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_index <= w_next_index;
                            vec     <= code_of(w_next_index);
                        end
                    end else begin
                        r_dwell <= r_dwell + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_index <= '0;
                    r_dwell <= '0;
                    vec     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/exhaustive_stim_gen.md
EXHAUSTIVE_STIM_GEN -- requirements
Module: exhaustive_stim_gen

Interface
REQ-001 The block SHALL have parameter N, default 4: width of the generated input vector, legal range 1..16.
REQ-002 The block SHALL have parameter DWELL, default 20: clock cycles each vector is held, legal range 2..65535.
REQ-003 The block SHALL have parameter EXP_TABLE, width 2^N, default all zeros: expected DUT output, where bit k is the expected result for vec == k.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request a sweep; sampled in IDLE or DONE.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of a running sweep.
REQ-008 The block SHALL have port f_in, input, 1 bit: DUT output under test.
REQ-009 The block SHALL have port vec, output, N bits: stimulus vector driven to the DUT.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sweep runs.
REQ-011 The block SHALL have port done, output, 1 bit: high from sweep completion until the next start or reset.
REQ-012 The block SHALL have port err_cnt, output, N+1 bits: count of mismatching vectors.
REQ-013 The block SHALL have port first_err_vec, output, N bits: vec value of the first mismatch.
REQ-014 The block SHALL have port first_err_vld, output, 1 bit: first_err_vec is valid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 and abort=0 at an edge SHALL cause the following: enter RUN, index=0, dwell counter=0, and clear err_cnt, first_err_vld and first_err_vec; busy=1 and done=0 from that edge.
REQ-017 In RUN, vec SHALL be held for exactly DWELL cycles per index, and f_in SHALL be compared against EXP_TABLE[vec] at the edge ending the DWELL-th cycle.
REQ-018 On a mismatch, err_cnt SHALL increment; if first_err_vld=0, the block SHALL also capture first_err_vec=vec and set first_err_vld=1 on the same edge.
REQ-019 At the compare edge with index < 2^N-1, index SHALL increment and the dwell counter SHALL clear; with index == 2^N-1, the FSM SHALL enter DONE, busy=0 and done=1.
REQ-020 A complete sweep SHALL keep busy high for exactly 2^N*DWELL cycles.
REQ-021 err_cnt SHALL never wrap; the maximum value is 2^N, which is representable in N+1 bits.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 abort in RUN SHALL cause the following at that edge: return to IDLE, busy=0, done=0, vec=0, with err_cnt and first_err_* held; abort in IDLE or DONE SHALL have no effect.
REQ-024 When start and abort are both high, abort SHALL win and the sweep SHALL not start.
REQ-025 In IDLE and DONE, vec SHALL be 0.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force: state=IDLE, vec=0, busy=0, done=0, err_cnt=0, first_err_vec=0, first_err_vld=0, with index and dwell counter at 0.
REQ-027 Reset asserted mid-sweep SHALL discard all progress, and no compare SHALL occur on the edge at which rst_n deasserts.

Configuration
REQ-028 The macro STIM_GRAY_EN SHALL select the vector ordering as follows: when defined, vec = index XOR (index >> 1), giving reflected Gray order with one bit changing per step; when undefined, vec = index, giving binary ascending order.
REQ-029 In both modes, every one of the 2^N codes SHALL be applied exactly once, and the compare SHALL always index EXP_TABLE by vec, not by index.

Verification
REQ-030 The bench SHALL cover a clean sweep: N=4, DWELL=20, EXP_TABLE=16'hA5C3, with the model driving f_in=EXP_TABLE[vec]; start pulse -> vec steps 0..15 at 20 cycles each, busy high 320 cycles, done=1, err_cnt=0, first_err_vld=0.
REQ-031 The bench SHALL cover fault injection: the same setup with f_in inverted while vec==5 and vec==12 -> err_cnt=2, first_err_vec=5, first_err_vld=1.
REQ-032 The bench SHALL cover abort: abort at cycle 100 of the sweep -> next edge IDLE, busy=0, done=0, vec=0; err_cnt holds its pre-abort value; a later start clears err_cnt and restarts at vec=0.
REQ-033 The bench SHALL cover reset mid-sweep: rst_n=0 at cycle 150 -> all outputs 0 asynchronously; start after release -> a full 320-cycle sweep.
REQ-034 The bench SHALL cover start while busy and start with abort: start pulses during RUN -> sweep length is unchanged; start and abort high together in IDLE -> remains in IDLE.
REQ-035 The bench SHALL cover STIM_GRAY_EN defined with N=3: vec sequence 0,1,3,2,6,7,5,4 with exactly one bit change per step; with f_in=EXP_TABLE[vec], err_cnt=0.
